// File: rtl/tracker_pkg.sv
// Shared definitions for the activity tracker: display mode encoding,
// digit codes, display clamp value, converter FSM states and the
// double-dabble digit adjust helper.
package tracker_pkg;

    localparam logic [1:0]  MODE_TOTAL     = 2'd0;
    localparam logic [1:0]  MODE_DIST      = 2'd1;
    localparam logic [1:0]  MODE_ACTIVE    = 2'd2;
    localparam logic [1:0]  MODE_PEAK      = 2'd3;

    localparam logic [4:0]  DIGIT_BLANK_US = 5'h1F;
    localparam logic [13:0] DISPLAY_CLAMP  = 14'd9999;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } conv_state_t;

    // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_conv_seq.sv
// Free-running 14-bit sequential binary-to-BCD converter (double-dabble).
// One conversion every 16 cycles: LOAD (sample value and tag), 14 x SHIFT,
// UPDATE (write digits). The tag travels with the value so the consumer
// can map the digits consistently with the quantity that was sampled.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   value  [13:0]     binary value to convert (<= 9999)
//   tag    [1:0]      side information sampled together with value
//   dig3..dig0 [3:0]  converted digits, dig3 most significant
//   tag_out [1:0]     tag belonging to the current digits
//   valid             one-cycle pulse after new digits are written
module bcd_conv_seq
    import tracker_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] value,
    input  logic [1:0]  tag,
    output logic [3:0]  dig3,
    output logic [3:0]  dig2,
    output logic [3:0]  dig1,
    output logic [3:0]  dig0,
    output logic [1:0]  tag_out,
    output logic        valid
);

    conv_state_t state_r;
    conv_state_t state_nx_s;
    logic [29:0] shreg_r;      // {bcd[15:0], bin[13:0]}
    logic [29:0] adj_s;
    logic [3:0]  cnt_r;
    logic [1:0]  tag_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: LOAD -> 14 x SHIFT -> UPDATE -> LOAD
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_LOAD: begin
                state_nx_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_r == 4'd13) begin
                    state_nx_s = ST_UPDATE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_UPDATE: begin
                state_nx_s = ST_LOAD;
            end
            default: begin
                state_nx_s = ST_LOAD;
            end
        endcase
    end

    // Per-nibble add-3 correction applied before each shift
    always_comb begin
        adj_s        = shreg_r;
        adj_s[29:26] = dabble_adj(shreg_r[29:26]);
        adj_s[25:22] = dabble_adj(shreg_r[25:22]);
        adj_s[21:18] = dabble_adj(shreg_r[21:18]);
        adj_s[17:14] = dabble_adj(shreg_r[17:14]);
    end

    // Conversion datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r <= 30'd0;
            cnt_r   <= 4'd0;
            tag_r   <= 2'd0;
            dig3    <= 4'd0;
            dig2    <= 4'd0;
            dig1    <= 4'd0;
            dig0    <= 4'd0;
            tag_out <= 2'd0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_r)
                ST_LOAD: begin
                    shreg_r <= {16'h0000, value};
                    cnt_r   <= 4'd0;
                    tag_r   <= tag;
                end
                ST_SHIFT: begin
                    shreg_r <= adj_s << 1;
                    cnt_r   <= cnt_r + 4'd1;
                end
                ST_UPDATE: begin
                    dig3    <= shreg_r[29:26];
                    dig2    <= shreg_r[25:22];
                    dig1    <= shreg_r[21:18];
                    dig0    <= shreg_r[17:14];
                    tag_out <= tag_r;
                    valid   <= 1'b1;
                end
                default: begin
                    shreg_r <= 30'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/activity_tracker.sv
// Pedometer core: debounces step pulses, keeps a saturating step total,
// derives distance in tenths, counts active seconds in the opening window
// and tracks the peak steps-per-second. A mode input selects which value
// is converted to four BCD digits for the seven-segment driver.
// Ports:
//   sys_clk, reset     system clock, synchronous active-high reset
//   step_in            raw asynchronous step sensor level
//   mode [1:0]         0 total, 1 distance, 2 active seconds, 3 peak rate
//   si                 total steps above MAX_DISPLAY
//   bcd3..bcd0 [4:0]   digit codes (0-9, 5'h1F underscore), bcd3 most significant
module activity_tracker
    import tracker_pkg::*;
#(
    parameter int CNT_W       = 31,
    parameter int MAX_DISPLAY = 9999,
    parameter int DIST_SHIFT  = 11,
    parameter int TICK_DIV    = 100_000_000,
    parameter int RATE_THRESH = 32,
    parameter int WINDOW_SECS = 9,
    parameter int RATE_W      = 14
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       step_in,
    input  logic [1:0] mode,
    output logic       si,
    output logic [4:0] bcd3,
    output logic [4:0] bcd2,
    output logic [4:0] bcd1,
    output logic [4:0] bcd0
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int WIN_W   = $clog2(WINDOW_SECS + 1);
    localparam int FRAC_W  = DIST_SHIFT + 4;

    logic               sync1_r, sync2_r, hist_r, pulse_r;
    logic [CNT_W-1:0]   total_r;
    logic [PRESC_W-1:0] presc_r;
    logic               tick_s;
    logic [RATE_W-1:0]  sec_steps_r, peak_r;
    logic [WIN_W-1:0]   active_r, secs_elapsed_r;
    logic [6:0]         whole_s;
    logic [3:0]         tenths_s;
    logic [13:0]        disp_val_s;
    logic [3:0]         dig3_s, dig2_s, dig1_s, dig0_s;
    logic [1:0]         conv_tag_s;
    logic               conv_valid_s;

    // Step synchroniser and rising-edge detector (pulse registered once more)
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            hist_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync1_r <= step_in;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
            pulse_r <= sync2_r & ~hist_r;
        end
    end

    // Saturating step total and over-range flag
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            total_r <= {CNT_W{1'b0}};
            si      <= 1'b0;
        end else begin
            if (pulse_r && (total_r != {CNT_W{1'b1}})) begin
                total_r <= total_r + CNT_W'(1);
            end
            si <= (total_r > CNT_W'(MAX_DISPLAY));
        end
    end

    // Seconds prescaler
    always_ff @(posedge sys_clk) begin
        if (reset || tick_s) begin
            presc_r <= {PRESC_W{1'b0}};
        end else begin
            presc_r <= presc_r + PRESC_W'(1);
        end
    end

    assign tick_s = (presc_r == PRESC_W'(TICK_DIV - 1));

    // Per-second rate, active-window and peak tracking; a pulse landing on
    // the tick belongs to the second that starts there
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sec_steps_r    <= {RATE_W{1'b0}};
            peak_r         <= {RATE_W{1'b0}};
            active_r       <= {WIN_W{1'b0}};
            secs_elapsed_r <= {WIN_W{1'b0}};
        end else if (tick_s) begin
            if (secs_elapsed_r < WIN_W'(WINDOW_SECS)) begin
                secs_elapsed_r <= secs_elapsed_r + WIN_W'(1);
                if (sec_steps_r > RATE_W'(RATE_THRESH)) begin
                    active_r <= active_r + WIN_W'(1);
                end
            end
            if (sec_steps_r > peak_r) begin
                peak_r <= sec_steps_r;
            end
            sec_steps_r <= pulse_r ? RATE_W'(1) : {RATE_W{1'b0}};
        end else if (pulse_r && (sec_steps_r != {RATE_W{1'b1}})) begin
            sec_steps_r <= sec_steps_r + RATE_W'(1);
        end
    end

    // Display value selection, including distance whole/tenths split
    always_comb begin
        if ((total_r >> DIST_SHIFT) > CNT_W'(99)) begin
            whole_s = 7'd99;
        end else begin
            whole_s = 7'(total_r >> DIST_SHIFT);
        end
        tenths_s = 4'(({4'b0000, total_r[DIST_SHIFT-1:0]} * FRAC_W'(10)) >> DIST_SHIFT);
        disp_val_s = 14'd0;
        case (mode)
            MODE_TOTAL: begin
                if (total_r > CNT_W'(DISPLAY_CLAMP)) begin
                    disp_val_s = DISPLAY_CLAMP;
                end else begin
                    disp_val_s = 14'(total_r);
                end
            end
            MODE_DIST: begin
                disp_val_s = 14'(whole_s) * 14'd10 + 14'(tenths_s);
            end
            MODE_ACTIVE: begin
                disp_val_s = 14'(active_r);
            end
            MODE_PEAK: begin
                if (peak_r > RATE_W'(DISPLAY_CLAMP)) begin
                    disp_val_s = DISPLAY_CLAMP;
                end else begin
                    disp_val_s = 14'(peak_r);
                end
            end
            default: begin
                disp_val_s = 14'd0;
            end
        endcase
    end

    bcd_conv_seq u_conv (
        .clk     (sys_clk),
        .reset   (reset),
        .value   (disp_val_s),
        .tag     (mode),
        .dig3    (dig3_s),
        .dig2    (dig2_s),
        .dig1    (dig1_s),
        .dig0    (dig0_s),
        .tag_out (conv_tag_s),
        .valid   (conv_valid_s)
    );

    // Output digit registers; the mode captured with the value decides the
    // layout, so all four digits always come from one conversion
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            bcd3 <= 5'd0;
            bcd2 <= 5'd0;
            bcd1 <= 5'd0;
            bcd0 <= 5'd0;
        end else if (conv_valid_s) begin
            if (conv_tag_s == MODE_DIST) begin
                bcd3 <= {1'b0, dig2_s};
                bcd2 <= {1'b0, dig1_s};
                bcd1 <= DIGIT_BLANK_US;
                bcd0 <= {1'b0, dig0_s};
            end else begin
                bcd3 <= {1'b0, dig3_s};
                bcd2 <= {1'b0, dig2_s};
                bcd1 <= {1'b0, dig1_s};
                bcd0 <= {1'b0, dig0_s};
            end
        end
    end

endmodule

// File: tb/tb_activity_tracker.sv
// Self-checking bench for activity_tracker with randomized step timing.
// The reference model records, per step, the cycle its pulse reaches the
// counters and the second it falls into, then derives total, distance,
// active seconds and peak from those records with plain arithmetic.
module tb_activity_tracker;

    localparam int CNT_W       = 14;
    localparam int MAX_DISPLAY = 9999;
    localparam int DIST_SHIFT  = 4;
    localparam int TICK_DIV    = 64;
    localparam int RATE_THRESH = 3;
    localparam int WINDOW_SECS = 9;
    localparam int RATE_W      = 14;
    localparam int TOTAL_MAX   = (1 << CNT_W) - 1;
    localparam int RATE_MAX    = (1 << RATE_W) - 1;
    localparam int NSEC        = 2048;

    logic        sys_clk;
    logic        reset;
    logic        step_in;
    logic [1:0]  mode;
    logic        si;
    logic [4:0]  bcd3, bcd2, bcd1, bcd0;
    logic [19:0] bcd_all;

    int cyc = 0;
    int r_edge;
    int nsteps;
    int sec_cnt [NSEC];
    int checks = 0;
    int failures = 0;

    assign bcd_all = {bcd3, bcd2, bcd1, bcd0};

    activity_tracker #(
        .CNT_W       (CNT_W),
        .MAX_DISPLAY (MAX_DISPLAY),
        .DIST_SHIFT  (DIST_SHIFT),
        .TICK_DIV    (TICK_DIV),
        .RATE_THRESH (RATE_THRESH),
        .WINDOW_SECS (WINDOW_SECS),
        .RATE_W      (RATE_W)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .step_in (step_in),
        .mode    (mode),
        .si      (si),
        .bcd3    (bcd3),
        .bcd2    (bcd2),
        .bcd1    (bcd1),
        .bcd0    (bcd0)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_model();
        nsteps = 0;
        for (int i = 0; i < NSEC; i++) sec_cnt[i] = 0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        r_edge = cyc;
        clear_model();
    endtask

    // One step: the rise is sampled at the next edge and reaches the
    // counters three edges after that.
    task automatic do_step();
        int e;
        int s;
        step_in = 1'b1;
        e = cyc + 4;
        s = (e - r_edge) / TICK_DIV + 1;
        if (s < NSEC) sec_cnt[s] = sec_cnt[s] + 1;
        nsteps++;
        gap(1);
        step_in = 1'b0;
        gap(1);
    endtask

    task automatic steps(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            do_step();
            if (maxgap > 0) gap($urandom_range(0, maxgap));
        end
    endtask

    task automatic align_sec();
        while (((cyc - r_edge) % TICK_DIV) != 0) gap(1);
    endtask

    function automatic int exp_total();
        return (nsteps > TOTAL_MAX) ? TOTAL_MAX : nsteps;
    endfunction

    function automatic int exp_active();
        int n = 0;
        for (int s = 1; s <= WINDOW_SECS; s++)
            if (sec_cnt[s] > RATE_THRESH) n++;
        return n;
    endfunction

    function automatic int exp_peak();
        int p = 0;
        for (int s = 1; s < NSEC; s++)
            if (sec_cnt[s] > p) p = sec_cnt[s];
        return (p > RATE_MAX) ? RATE_MAX : p;
    endfunction

    function automatic logic [19:0] digits4(input int v);
        return {5'(v / 1000), 5'((v / 100) % 10), 5'((v / 10) % 10), 5'(v % 10)};
    endfunction

    function automatic logic [19:0] exp_disp(input logic [1:0] m);
        int t;
        int w;
        int tn;
        int pk;
        t = exp_total();
        case (m)
            2'd0: return digits4((t > 9999) ? 9999 : t);
            2'd1: begin
                w = t / (1 << DIST_SHIFT);
                if (w > 99) w = 99;
                tn = ((t % (1 << DIST_SHIFT)) * 10) / (1 << DIST_SHIFT);
                return {5'(w / 10), 5'(w % 10), 5'h1F, 5'(tn)};
            end
            2'd2: return digits4(exp_active());
            default: begin
                pk = exp_peak();
                return digits4((pk > 9999) ? 9999 : pk);
            end
        endcase
    endfunction

    task automatic check_disp(input string tag, input logic [1:0] m, input int settle);
        mode = m;
        gap(settle);
        chk(tag, 32'(bcd_all), 32'(exp_disp(m)));
    endtask

    initial begin
        int b;
        sys_clk = 1'b0;
        reset   = 1'b1;
        step_in = 1'b0;
        mode    = 2'd0;
        r_edge  = 0;
        clear_model();

        // reset values
        gap(3);
        chk("rst_bcd", 32'(bcd_all), 32'd0);
        chk("rst_si", 32'(si), 32'd0);
        reset = 1'b0;
        r_edge = cyc;

        // five clean steps, mode 0
        steps(5, 5);
        check_disp("five_steps", 2'd0, 48);
        chk("five_si", 32'(si), 32'd0);

        // distance: 40 steps at 16 steps/unit, then random increments
        do_reset();
        steps(40, 3);
        check_disp("dist_40", 2'd1, 48);
        for (int it = 0; it < 4; it++) begin
            steps($urandom_range(1, 70), 2);
            check_disp("rand_total", 2'd0, 48);
            check_disp("rand_dist", 2'd1, 48);
        end

        // activity window: 12 seconds of random counts around the threshold,
        // then one busy second
        do_reset();
        for (int sec = 0; sec < 12; sec++) begin
            align_sec();
            steps($urandom_range(1, 7), 0);
        end
        align_sec();
        steps(20, 0);
        check_disp("win_active", 2'd2, 140);
        check_disp("win_peak", 2'd3, 140);

        // step landing exactly on the tick belongs to the new second
        do_reset();
        align_sec();
        steps(3, 0);
        b = r_edge + TICK_DIV * ((cyc + 4 - r_edge) / TICK_DIV + 1);
        while (cyc < b - 4) gap(1);
        do_step();
        steps(4, 0);
        check_disp("coin_active", 2'd2, 140);
        check_disp("coin_peak", 2'd3, 48);
        check_disp("coin_total", 2'd0, 48);

        // display clamp, over-range flag and total saturation
        do_reset();
        steps(9999, 0);
        gap(8);
        chk("si_at_9999", 32'(si), 32'd0);
        do_step();
        gap(8);
        chk("si_at_10000", 32'(si), 32'd1);
        do_step();
        check_disp("clamp_total", 2'd0, 48);
        check_disp("clamp_dist", 2'd1, 48);
        steps(10, 0);
        check_disp("no_wrap", 2'd0, 48);
        steps(TOTAL_MAX + 5 - nsteps, 0);
        gap(8);
        chk("sat_si", 32'(si), 32'd1);
        check_disp("sat_dist", 2'd1, 48);
        check_disp("sat_total", 2'd0, 48);
        check_disp("sat_active", 2'd2, 140);
        check_disp("sat_peak", 2'd3, 48);

        // reset in the middle of a conversion with mode 3 showing
        gap($urandom_range(0, 15));
        reset = 1'b1;
        gap(1);
        chk("midrst_bcd", 32'(bcd_all), 32'd0);
        chk("midrst_si", 32'(si), 32'd0);
        gap(1);
        reset = 1'b0;
        r_edge = cyc;
        clear_model();
        check_disp("post_rst_peak", 2'd3, 20);
        check_disp("post_rst_total", 2'd0, 48);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/activity_tracker.md
# activity_tracker

Second-generation pedometer core: counts debounced step pulses, derives distance in tenths of a unit, counts high-activity seconds within a configurable opening window, and tracks peak steps-per-second. All logic runs on one system clock with an internal seconds prescaler. A mode input selects which quantity drives the four 5-bit BCD digit outputs feeding the seven-segment display driver.

## Interface
- `CNT_W`, 31: total step counter width.
- `MAX_DISPLAY`, 9999: value above which `si` asserts and display clamps.
- `DIST_SHIFT`, 11: steps per distance unit = 2^DIST_SHIFT, ≥ 4.
- `TICK_DIV`, 100_000_000: `sys_clk` cycles per second tick, ≥ 32.
- `RATE_THRESH`, 32: a second is "active" if its step count > this.
- `WINDOW_SECS`, 9: number of opening seconds evaluated for activity.
- `RATE_W`, 14: per-second and peak counter width (saturating).

Ports:
- `sys_clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `step_in`  in  1  raw asynchronous step sensor level.
- `mode`  in  2  0 total steps, 1 distance, 2 active seconds, 3 peak rate.
- `si`  out  1  total steps > MAX_DISPLAY.
- `bcd3`, `bcd2`, `bcd1`, `bcd0`  out  5 each  digit codes (0–9, 0x1F = underscore), bcd3 most significant.

## Operation
- Step detect: `step_in` through 2-FF synchroniser plus one history FF; `step_pulse` = sync & ~history. Each rising edge of `step_in` yields exactly one pulse.
- Total: `total` += 1 per pulse, saturates at 2^CNT_W−1 (never wraps). `si` = (total > MAX_DISPLAY), registered.
- Prescaler: counter 0..TICK_DIV−1; `tick` 1-cycle pulse on wrap to 0.
- Per second: `sec_steps` counts pulses, saturating at 2^RATE_W−1. On `tick`: evaluate `sec_steps`, then reload with 1 if `step_pulse` same cycle, else 0 (coincident step belongs to new second).
- On `tick`: if `secs_elapsed` < WINDOW_SECS and `sec_steps` > RATE_THRESH, `active_secs`++; `secs_elapsed` increments, saturating at WINDOW_SECS. `peak` = max(peak, sec_steps).
- Distance: whole = total >> DIST_SHIFT, clamp 99; tenths = (total[DIST_SHIFT−1:0] × 10) >> DIST_SHIFT (0–9, truncated).
- Display value (14-bit): mode 0 min(total, 9999); mode 1 whole×10+tenths; mode 2 active_secs; mode 3 min(peak, 9999).
- Converter FSM (sub-module): LOAD (1 cycle, sample display value) → SHIFT (14 cycles, double-dabble) → UPDATE (1 cycle, write outputs) → LOAD. Free-running, period 16 cycles.
- Output mapping: modes 0/2/3 → four converted digits, leading zeros shown. Mode 1 → bcd3 = hundreds digit (whole tens), bcd2 = tens digit (whole units), bcd1 = 0x1F, bcd0 = units digit (tenths).

## Timing
- Reset values: all counters, `peak`, `active_secs`, `secs_elapsed`, prescaler 0; `si` 0; all bcd 0; FSM in LOAD; sync FFs 0.
- `step_in` rise sampled at edge k → `total` updated at edge k+3 → `si` at k+4.
- Display latency: value sampled in LOAD appears on bcd outputs 16 cycles later; worst-case display update ≤ 32 cycles after a counter change.
- `mode` change: mid-conversion ignored; new mode takes effect at next LOAD. Outputs never show mixed-mode digits.
- Reset mid-conversion: FSM to LOAD, outputs 0 next cycle.
- Saturated counters hold; pulses then have no effect except on non-saturated counters.
- Window: seconds after WINDOW_SECS never change `active_secs`; `peak` updates on every tick.

## Structure
- Shared package `tracker_pkg`: mode encoding constants, `DIGIT_BLANK_US` = 5'h1F, `DISPLAY_CLAMP` = 9999, FSM state typedef.
- One sub-module `bcd_conv_seq` (14-bit iterative double-dabble, LOAD/SHIFT/UPDATE FSM, four 4-bit digit outputs, `valid` pulse in UPDATE).

## Test plan
- Reset, mode 0, 5 clean step pulses → within 32 cycles bcd = 0,0,0,5; `si` = 0.
- 10001 steps, mode 0 → `si` = 1, bcd = 9,9,9,9; 10 more steps → still 9,9,9,9, no wrap.
- DIST_SHIFT = 4, mode 1, 40 steps → 2.5 units → bcd = 0,2,0x1F,5; 1600+ steps → whole clamps, bcd3/bcd2 = 9,9.
- TICK_DIV = 64, RATE_THRESH = 3, WINDOW_SECS = 9: 12 seconds of 5 steps each → mode 2 shows 0,0,0,9; one later second with 20 steps → mode 3 shows 0,0,2,0.
- Step pulse coincident with `tick` → previous second's count excludes it, new `sec_steps` = 1, `total` +1.
- Assert `reset` during SHIFT with mode 3 active → next cycle all bcd = 0, all counters 0; first post-reset conversion shows 0,0,0,0.
